// File: rtl/fxp_div3_seq.sv
// Sequential signed Q2.6 divide-by-3: restoring divider on |din|, one quotient bit
// per cycle, then sign fix-up. Results are registered and flagged by a done pulse.
module fxp_div3_seq #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [1:0]       rem,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request that is taken only on an edge where the unit is
  // idle (busy = 0); din is captured on that same edge. done pulses for one cycle
  // when quot/rem are updated; requests while busy are dropped, never queued.

  // The divisor is an integer, so FRAC only needs to leave a sign bit in the word.
  localparam int STEPS = (FRAC < WIDTH) ? WIDTH : 0;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state;
  logic             neg;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] q_acc;
  logic [2:0]       part;
  logic [CNT_W-1:0] cnt;

  logic [2:0] shifted;
  logic       q_bit;
  logic [2:0] part_next;

  assign dbg_state = state;

  always_comb begin
    shifted   = {part[1:0], mag[cnt]};
    q_bit     = (shifted >= 3'd3);
    part_next = q_bit ? (shifted - 3'd3) : shifted;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= S_IDLE;
      neg   <= 1'b0;
      mag   <= '0;
      q_acc <= '0;
      part  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            neg   <= din[WIDTH-1];
            // Two's-complement negate; the most negative code maps to its own
            // unsigned magnitude, which is exactly what the divider needs.
            mag   <= din[WIDTH-1] ? (~din + 1'b1) : din;
            q_acc <= '0;
            part  <= '0;
            cnt   <= CNT_W'(STEPS - 1);
            busy  <= 1'b1;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          part  <= part_next;
          q_acc <= {q_acc[WIDTH-2:0], q_bit};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          quot  <= neg ? (~q_acc + 1'b1) : q_acc;
          rem   <= part[1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div3_seq.sv
// Bench for fxp_div3_seq: directed corner cases, random samples and a back-to-back
// sweep of every input code, all scored against an integer-arithmetic model.
module tb_fxp_div3_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] quot;
  logic [1:0] rem;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q[$];

  fxp_div3_seq #(.WIDTH(8), .FRAC(6)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .quot      (quot),
    .rem       (rem),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer division truncates toward zero.
  function automatic logic [9:0] model(input logic [7:0] d);
    int v, m;
    logic [7:0] q;
    logic [1:0] r;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    q = 8'(v / 3);
    r = 2'(m % 3);
    return {q, r};
  endfunction

  // Watches one job from the cycle after its accepting edge. Optionally pokes
  // start/din at cycle poke_n to confirm the running job ignores them.
  task automatic collect(input string tag, input logic [7:0] d, input int poke_n,
                         input logic [7:0] poke_din, input logic poke_start);
    int n = 0;
    int busy_n = 0;
    logic seen = 1'b0;
    logic overlap = 1'b0;
    logic moved = 1'b0;
    logic [9:0] held;
    logic [9:0] e;
    e = model(d);
    held = {quot, rem};
    while (n < 20) begin
      if (done) begin
        seen = 1'b1;
        if (busy) overlap = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if ({quot, rem} !== held) moved = 1'b1;
      if (n == poke_n) begin
        din = poke_din;
        start = poke_start;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, n, 9);
      check({tag, "_busy_cycles"}, busy_n, 9);
      check({tag, "_busy_at_done"}, {31'd0, overlap}, 0);
      check({tag, "_held"}, {31'd0, moved}, 0);
      check({tag, "_quot"}, quot, e[9:2]);
      check({tag, "_rem"}, rem, e[1:0]);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 0);
      check({tag, "_idle_after"}, {31'd0, busy}, 0);
    end
  endtask

  task automatic run_one(input logic [7:0] d, input string tag, input int poke_n = -1,
                         input logic [7:0] poke_din = 8'h00, input logic poke_start = 1'b0);
    @(negedge clk);
    din = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(tag, d, poke_n, poke_din, poke_start);
  endtask

  task automatic reset_mid_run();
    int n;
    logic spurious = 1'b0;
    @(negedge clk);
    din = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 5; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_done", {31'd0, done}, 0);
    check("rst_mid_quot", quot, 0);
    check("rst_mid_rem", rem, 0);
    for (n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) spurious = 1'b1;
    end
    check("rst_mid_no_done", {31'd0, spurious}, 0);
  endtask

  task automatic sweep();
    int idx = 0;
    int cyc = 0;
    int last = -1;
    int got_n = 0;
    logic [9:0] e;
    @(negedge clk);
    din = 8'(idx);
    start = 1'b1;
    exp_q.push_back(model(8'(idx)));
    while (got_n < 256 && cyc < 256 * 10 + 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = exp_q.pop_front();
        check("sweep_result", {22'd0, quot, rem}, {22'd0, e});
        if (last >= 0) check("sweep_spacing", cyc - last, 10);
        last = cyc;
        got_n++;
        idx++;
        if (idx < 256) begin
          din = 8'(idx);
          exp_q.push_back(model(8'(idx)));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("sweep_count", got_n, 256);
    check("sweep_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_quot", quot, 0);
    check("reset_rem", rem, 0);

    // reset and start on the same edge: reset wins
    din = 8'h40;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_vs_start_busy", {31'd0, busy}, 0);
    @(negedge clk);
    check("rst_vs_start_idle", {31'd0, busy}, 0);

    run_one(8'h40, "pos_one");
    run_one(8'hC0, "neg_one");
    run_one(8'h80, "most_neg");
    run_one(8'h7F, "most_pos");
    run_one(8'h02, "small_pos");
    run_one(8'hFE, "small_neg");
    run_one(8'h03, "exact_three");
    run_one(8'h40, "start_while_busy", 3, 8'h7F, 1'b1);
    run_one(8'hA5, "din_changes", 3, 8'h11, 1'b0);

    reset_mid_run();
    run_one(8'h40, "after_reset");

    for (int i = 0; i < 20; i++) begin
      run_one(8'($urandom_range(0, 255)), "random");
    end

    sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
